ni_config_reader: RTL and testbench

Bus initiator that discovers a tile's network-adapter configuration by walking the NI configuration register file over the generic bus after a start request. It captures every scalar register plus the compute-tile list into a local snapshot and exposes them as ports. It sits in the tile next to the NA config responder and lets boot/DMA hardware read tile topology without software involvement.

---
 rtl/ni_config_pkg.sv | 52 +++++
 rtl/ni_config_reader.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_ni_config_reader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ni_config_pkg.sv
// Shared definitions for the NI configuration register file: word indices,
// CONF bit positions and the reader FSM state encoding.
package ni_config_pkg;

  // Word indices of the scalar registers inside the config region
  localparam logic [9:0] REG_TILEID          = 10'd0;
  localparam logic [9:0] REG_NUMTILES        = 10'd1;
  localparam logic [9:0] REG_CONF            = 10'd3;
  localparam logic [9:0] REG_COREBASE        = 10'd4;
  localparam logic [9:0] REG_DOMAIN_NUMCORES = 10'd6;
  localparam logic [9:0] REG_GMEM_SIZE       = 10'd7;
  localparam logic [9:0] REG_GMEM_TILE       = 10'd8;
  localparam logic [9:0] REG_LMEM_SIZE       = 10'd9;
  localparam logic [9:0] REG_NUMCTS          = 10'd10;
  localparam logic [9:0] REG_SEED            = 10'd11;

  // Word index where the packed 16-bit compute-tile list begins
  localparam logic [9:0] REG_CTLIST          = 10'h80;

  // CONF register bit positions
  localparam int CONF_MPSIMPLE_BIT = 0;
  localparam int CONF_DMA_BIT      = 1;

  // Number of scalar registers fetched before the CT list
  localparam int NUM_SCALARS = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_SCALAR = 2'd1,
    RD_CT     = 2'd2
  } ni_cfg_state_e;

  // Fetch order of the scalar registers: sequence position -> word index
  function automatic logic [9:0] scalar_word(input logic [3:0] idx);
    logic [9:0] w;
    case (idx)
      4'd0:    w = REG_TILEID;
      4'd1:    w = REG_NUMTILES;
      4'd2:    w = REG_CONF;
      4'd3:    w = REG_COREBASE;
      4'd4:    w = REG_DOMAIN_NUMCORES;
      4'd5:    w = REG_GMEM_SIZE;
      4'd6:    w = REG_GMEM_TILE;
      4'd7:    w = REG_LMEM_SIZE;
      4'd8:    w = REG_NUMCTS;
      4'd9:    w = REG_SEED;
      default: w = REG_TILEID;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ni_config_reader.sv
// ni_config_reader: bus initiator that walks the NI config register file after
// a start request and keeps a local snapshot of the scalars and the CT list.
module ni_config_reader
  import ni_config_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_CTS   = 64,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        error,
  output logic        err_timeout,
  output logic        ct_trunc,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic        bus_en,
  output logic [31:0] bus_data_out,
  input  logic [31:0] bus_data_in,
  input  logic        bus_ack,
  input  logic        bus_err,
  output logic [31:0] tileid,
  output logic [31:0] numtiles,
  output logic [31:0] corebase,
  output logic [31:0] numcores,
  output logic [31:0] gmem_size,
  output logic [31:0] gmem_tile,
  output logic [31:0] lmem_size,
  output logic [31:0] numcts,
  output logic [31:0] seed,
  output logic        conf_mpsimple,
  output logic        conf_dma,
  input  logic [5:0]  ct_idx,
  output logic [15:0] ct_tileid
);

  // Storage is sized for the full 6-bit index; slots at or above MAX_CTS are never written
  localparam int          CT_SLOTS    = 64;
  localparam logic [31:0] CT_BYTE_OFS = {20'd0, REG_CTLIST, 2'b00};
  localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT - 1);

  ni_cfg_state_e state_q, state_d;
  logic [3:0]  sc_idx_q, sc_idx_d;
  logic [6:0]  ct_i_q, ct_i_d;
  logic [6:0]  ct_cnt_q, ct_cnt_d;
  logic [15:0] wait_q, wait_d;
  logic        bus_en_q, bus_en_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        err_to_q, err_to_d;
  logic        trunc_q, trunc_d;
  logic [31:0] tileid_q, tileid_d;
  logic [31:0] numtiles_q, numtiles_d;
  logic [1:0]  conf_q, conf_d;
  logic [31:0] corebase_q, corebase_d;
  logic [31:0] numcores_q, numcores_d;
  logic [31:0] gmem_size_q, gmem_size_d;
  logic [31:0] gmem_tile_q, gmem_tile_d;
  logic [31:0] lmem_size_q, lmem_size_d;
  logic [31:0] numcts_q, numcts_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] ct_q [CT_SLOTS];

  logic        rsp_ok, rsp_err, rsp_to;
  logic        ct_clear, ct_we;
  logic [6:0]  cnt_sel;
  logic [6:0]  ct_next;
  logic [15:0] ct_half;

  // Next-state logic: start handling, access handshake, capture and abort
  always_comb begin
    state_d     = state_q;
    sc_idx_d    = sc_idx_q;
    ct_i_d      = ct_i_q;
    ct_cnt_d    = ct_cnt_q;
    wait_d      = wait_q;
    bus_en_d    = bus_en_q;
    bus_addr_d  = bus_addr_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    error_d     = error_q;
    err_to_d    = err_to_q;
    trunc_d     = trunc_q;
    tileid_d    = tileid_q;
    numtiles_d  = numtiles_q;
    conf_d      = conf_q;
    corebase_d  = corebase_q;
    numcores_d  = numcores_q;
    gmem_size_d = gmem_size_q;
    gmem_tile_d = gmem_tile_q;
    lmem_size_d = lmem_size_q;
    numcts_d    = numcts_q;
    seed_d      = seed_q;
    ct_clear    = 1'b0;
    ct_we       = 1'b0;
    cnt_sel     = 7'd0;
    ct_next     = ct_i_q + 7'd1;

    // bus_err dominates a coincident bus_ack
    rsp_err = bus_en_q & bus_err;
    rsp_ok  = bus_en_q & bus_ack & ~bus_err;
    rsp_to  = bus_en_q & ~bus_ack & ~bus_err & (wait_q == WAIT_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          valid_d    = 1'b0;
          error_d    = 1'b0;
          err_to_d   = 1'b0;
          trunc_d    = 1'b0;
          ct_clear   = 1'b1;
          sc_idx_d   = 4'd0;
          ct_i_d     = 7'd0;
          wait_d     = 16'd0;
          bus_en_d   = 1'b1;
          bus_addr_d = BASE_ADDR + {20'd0, scalar_word(4'd0), 2'b00};
          state_d    = RD_SCALAR;
        end
      end

      RD_SCALAR, RD_CT: begin
        if (rsp_err || rsp_to) begin
          bus_en_d = 1'b0;
          done_d   = 1'b1;
          error_d  = 1'b1;
          err_to_d = rsp_to;
          valid_d  = 1'b0;
          state_d  = IDLE;
        end else if (rsp_ok) begin
          wait_d = 16'd0;
          if (state_q == RD_SCALAR) begin
            case (sc_idx_q)
              4'd0:    tileid_d    = bus_data_in;
              4'd1:    numtiles_d  = bus_data_in;
              4'd2:    conf_d      = {bus_data_in[CONF_DMA_BIT], bus_data_in[CONF_MPSIMPLE_BIT]};
              4'd3:    corebase_d  = bus_data_in;
              4'd4:    numcores_d  = bus_data_in;
              4'd5:    gmem_size_d = bus_data_in;
              4'd6:    gmem_tile_d = bus_data_in;
              4'd7:    lmem_size_d = bus_data_in;
              4'd8:    numcts_d    = bus_data_in;
              4'd9:    seed_d      = bus_data_in;
              default: ;
            endcase
            if (sc_idx_q == 4'(NUM_SCALARS - 1)) begin
              // NUMCTS was captured on the previous access
              if (numcts_q > 32'(MAX_CTS)) begin
                cnt_sel = 7'(MAX_CTS);
                trunc_d = 1'b1;
              end else begin
                cnt_sel = numcts_q[6:0];
              end
              ct_cnt_d = cnt_sel;
              if (cnt_sel == 7'd0) begin
                bus_en_d = 1'b0;
                done_d   = 1'b1;
                valid_d  = 1'b1;
                state_d  = IDLE;
              end else begin
                ct_i_d     = 7'd0;
                bus_addr_d = BASE_ADDR + CT_BYTE_OFS;
                state_d    = RD_CT;
              end
            end else begin
              sc_idx_d   = sc_idx_q + 4'd1;
              bus_addr_d = BASE_ADDR + {20'd0, scalar_word(sc_idx_q + 4'd1), 2'b00};
            end
          end else begin
            ct_we = 1'b1;
            if (ct_next == ct_cnt_q) begin
              bus_en_d = 1'b0;
              done_d   = 1'b1;
              valid_d  = 1'b1;
              state_d  = IDLE;
            end else begin
              ct_i_d     = ct_next;
              bus_addr_d = BASE_ADDR + CT_BYTE_OFS + {24'd0, ct_next, 1'b0};
            end
          end
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and snapshot registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sc_idx_q    <= 4'd0;
      ct_i_q      <= 7'd0;
      ct_cnt_q    <= 7'd0;
      wait_q      <= 16'd0;
      bus_en_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      err_to_q    <= 1'b0;
      trunc_q     <= 1'b0;
      tileid_q    <= 32'd0;
      numtiles_q  <= 32'd0;
      conf_q      <= 2'd0;
      corebase_q  <= 32'd0;
      numcores_q  <= 32'd0;
      gmem_size_q <= 32'd0;
      gmem_tile_q <= 32'd0;
      lmem_size_q <= 32'd0;
      numcts_q    <= 32'd0;
      seed_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      sc_idx_q    <= sc_idx_d;
      ct_i_q      <= ct_i_d;
      ct_cnt_q    <= ct_cnt_d;
      wait_q      <= wait_d;
      bus_en_q    <= bus_en_d;
      bus_addr_q  <= bus_addr_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      err_to_q    <= err_to_d;
      trunc_q     <= trunc_d;
      tileid_q    <= tileid_d;
      numtiles_q  <= numtiles_d;
      conf_q      <= conf_d;
      corebase_q  <= corebase_d;
      numcores_q  <= numcores_d;
      gmem_size_q <= gmem_size_d;
      gmem_tile_q <= gmem_tile_d;
      lmem_size_q <= lmem_size_d;
      numcts_q    <= numcts_d;
      seed_q      <= seed_d;
    end
  end

  // Even entries sit in the upper half of a list word, odd entries in the lower half
  assign ct_half = ct_i_q[0] ? bus_data_in[15:0] : bus_data_in[31:16];

  // CT snapshot: cleared on reset and on every accepted start, written per CT ack
  always_ff @(posedge clk) begin
    if (!rst_n || ct_clear) begin
      for (int i = 0; i < CT_SLOTS; i++) begin
        ct_q[i] <= 16'd0;
      end
    end else if (ct_we) begin
      ct_q[ct_i_q[5:0]] <= ct_half;
    end
  end

  assign ct_tileid = ({1'b0, ct_idx} < 7'(MAX_CTS)) ? ct_q[ct_idx] : 16'd0;

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign valid         = valid_q;
  assign error         = error_q;
  assign err_timeout   = err_to_q;
  assign ct_trunc      = trunc_q;
  assign bus_addr      = bus_addr_q;
  assign bus_en        = bus_en_q;
  assign bus_we        = 1'b0;
  assign bus_data_out  = 32'd0;
  assign tileid        = tileid_q;
  assign numtiles      = numtiles_q;
  assign corebase      = corebase_q;
  assign numcores      = numcores_q;
  assign gmem_size     = gmem_size_q;
  assign gmem_tile     = gmem_tile_q;
  assign lmem_size     = lmem_size_q;
  assign numcts        = numcts_q;
  assign seed          = seed_q;
  assign conf_mpsimple = conf_q[0];
  assign conf_dma      = conf_q[1];

endmodule

// File: tb/tb_ni_config_reader.sv
// Self-checking bench for ni_config_reader: a behavioural bus responder with
// configurable wait states and faults, plus a reference model of the walk.
module tb_ni_config_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, valid, error, err_timeout, ct_trunc;
  logic [31:0] bus_addr, bus_data_out;
  logic        bus_we, bus_en;
  logic [31:0] bus_data_in = 32'd0;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] tileid, numtiles, corebase, numcores, gmem_size, gmem_tile;
  logic [31:0] lmem_size, numcts, seed;
  logic        conf_mpsimple, conf_dma;
  logic [5:0]  ct_idx = 6'd0;
  logic [15:0] ct_tileid;

  always #5 clk = ~clk;

  ni_config_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .valid(valid), .error(error), .err_timeout(err_timeout), .ct_trunc(ct_trunc),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_ack(bus_ack), .bus_err(bus_err),
    .tileid(tileid), .numtiles(numtiles), .corebase(corebase), .numcores(numcores),
    .gmem_size(gmem_size), .gmem_tile(gmem_tile), .lmem_size(lmem_size),
    .numcts(numcts), .seed(seed), .conf_mpsimple(conf_mpsimple), .conf_dma(conf_dma),
    .ct_idx(ct_idx), .ct_tileid(ct_tileid)
  );

  int vectors = 0;
  int miscompares = 0;

  // Responder memory (word addressed) and the CT list it is packed from
  logic [31:0] mem [1024];
  logic [15:0] ct_list [128];

  // Responder control: wait states, fault address and kind (1 err, 2 err+ack, 3 hang)
  int          wait_states = 0;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;
  int          fault_kind = 0;
  int          rsp_cnt = 0;
  int          acc_num = 0;
  logic [31:0] last_addr = 32'd0;

  // Byte offsets of the scalar registers in fetch order
  int sc_off [10] = '{0, 4, 12, 16, 24, 28, 32, 36, 40, 44};

  // Reference snapshot
  logic [31:0] exp_sc [10];
  logic [15:0] exp_ct [64];
  logic        exp_valid, exp_error, exp_to, exp_trunc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] acc_addr(input int k);
    if (k < 10) return 32'(sc_off[k]);
    return 32'h200 + 32'(2 * (k - 10));
  endfunction

  function automatic logic [31:0] dut_sc(input int k);
    case (k)
      0: return tileid;
      1: return numtiles;
      2: return {30'd0, conf_dma, conf_mpsimple};
      3: return corebase;
      4: return numcores;
      5: return gmem_size;
      6: return gmem_tile;
      7: return lmem_size;
      8: return numcts;
      default: return seed;
    endcase
  endfunction

  // Bus responder: answers after wait_states cycles, checks the access order
  always @(negedge clk) begin
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_data_in = $urandom;
    if (!bus_en) begin
      rsp_cnt = 0;
    end else if (fault_kind == 3 && bus_addr == fault_addr) begin
      rsp_cnt = 0;
    end else if (rsp_cnt < wait_states) begin
      rsp_cnt++;
    end else begin
      rsp_cnt = 0;
      check($sformatf("addr%0d", acc_num), bus_addr, acc_addr(acc_num));
      last_addr = bus_addr;
      acc_num++;
      if ((fault_kind == 1 || fault_kind == 2) && bus_addr == fault_addr) begin
        bus_err = 1'b1;
        bus_ack = (fault_kind == 2);
      end else begin
        bus_ack = 1'b1;
        bus_data_in = mem[bus_addr[11:2]];
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 128; i++) ct_list[i] = 16'($urandom);
  endtask

  task automatic load_ct();
    for (int j = 0; j < 64; j++) mem[128 + j] = {ct_list[2 * j], ct_list[2 * j + 1]};
  endtask

  task automatic check_snapshot(input string tag);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s/sc%0d", tag, k), dut_sc(k), (k == 2) ? (exp_sc[k] & 32'h3) : exp_sc[k]);
    for (int i = 0; i < 64; i++) begin
      ct_idx = 6'(i);
      #1;
      check($sformatf("%s/ct%0d", tag, i), ct_tileid, exp_ct[i]);
    end
    ct_idx = 6'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/done"}, done, 0);
    check({tag, "/valid"}, valid, 0);
    check({tag, "/error"}, error, 0);
    check({tag, "/err_to"}, err_timeout, 0);
    check({tag, "/trunc"}, ct_trunc, 0);
    check({tag, "/addr"}, bus_addr, 0);
    check({tag, "/en"}, bus_en, 0);
    check({tag, "/we"}, bus_we, 0);
    check({tag, "/dout"}, bus_data_out, 0);
    for (int k = 0; k < 10; k++) exp_sc[k] = 32'd0;
    for (int i = 0; i < 64; i++) exp_ct[i] = 16'd0;
    check_snapshot(tag);
  endtask

  // One discovery walk: model the outcome, run it, compare everything
  task automatic run_walk(input string tag, input int w, input bit poke);
    int n, total, exp_resp, exp_cyc, cyc, fault_pos;
    bit faulted;
    n = (mem[10] > 32'd64) ? 64 : int'(mem[10]);
    total = 10 + n;
    exp_valid = 0; exp_error = 0; exp_to = 0; exp_trunc = 0;
    for (int i = 0; i < 64; i++) exp_ct[i] = 16'd0;
    exp_resp = 0; exp_cyc = 1; faulted = 0; fault_pos = total;
    for (int k = 0; k < total; k++) begin
      if (fault_kind != 0 && acc_addr(k) == fault_addr) begin
        faulted = 1; fault_pos = k; exp_error = 1;
        if (fault_kind == 3) begin
          exp_to = 1;
          exp_cyc += 16;
        end else begin
          exp_resp++;
          exp_cyc += w + 1;
        end
        break;
      end
      exp_resp++;
      exp_cyc += w + 1;
      if (k < 10) exp_sc[k] = mem[sc_off[k] / 4];
      else exp_ct[k - 10] = ct_list[k - 10];
    end
    exp_valid = !faulted;
    exp_trunc = (fault_pos >= 10) && (mem[10] > 32'd64);

    acc_num = 0;
    wait_states = w;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check({tag, "/busy1"}, busy, 1);
    check({tag, "/en1"}, bus_en, 1);
    check({tag, "/we"}, bus_we, 0);
    check({tag, "/dout"}, bus_data_out, 0);
    while (done !== 1'b1 && cyc < 2000) begin
      if (poke && cyc == 4) start = 1'b1;
      if (poke && cyc == 5) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    $display("walk %s: numcts=%0h wait=%0d fault=%0d@%0h done_cycle=%0d expected=%0d",
             tag, mem[10], w, fault_kind, fault_addr, cyc, exp_cyc);
    check({tag, "/done_cyc"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "/busy_end"}, busy, 0);
    check({tag, "/en_end"}, bus_en, 0);
    check({tag, "/valid"}, valid, exp_valid);
    check({tag, "/error"}, error, exp_error);
    check({tag, "/err_to"}, err_timeout, exp_to);
    check({tag, "/trunc"}, ct_trunc, exp_trunc);
    check({tag, "/accesses"}, 64'(acc_num), 64'(exp_resp));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (c == 0) check({tag, "/done_pulse"}, done, 0);
      check({tag, "/en_idle"}, bus_en, 0);
    end
    check_snapshot(tag);
  endtask

  initial begin
    int r;
    for (int k = 0; k < 10; k++) exp_sc[k] = 32'd0;
    for (int i = 0; i < 64; i++) exp_ct[i] = 16'd0;
    fill_random();
    load_ct();

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Directed walk with three CTs
    fill_random();
    mem[0] = 32'd5; mem[1] = 32'd16; mem[3] = 32'd3; mem[10] = 32'd3;
    ct_list[0] = 16'd2; ct_list[1] = 16'd7; ct_list[2] = 16'd9;
    load_ct();
    fault_kind = 0;
    run_walk("three_cts", 0, 0);
    check("three_cts/tileid", tileid, 32'd5);
    check("three_cts/mpsimple", conf_mpsimple, 1);
    check("three_cts/dma", conf_dma, 1);

    // No CTs
    fill_random(); mem[10] = 32'd0; load_ct();
    run_walk("zero_cts", 0, 0);

    // Truncated CT list
    fill_random(); mem[10] = 32'd70; load_ct();
    run_walk("trunc70", 0, 0);
    check("trunc70/last_addr", last_addr, 32'h27E);

    // bus_err on GMEM_TILE
    fill_random(); mem[10] = 32'd5; load_ct();
    fault_kind = 1; fault_addr = 32'h20;
    run_walk("err_gmem_tile", 0, 0);

    // Hang on COREBASE, then repaired
    fill_random(); mem[10] = 32'd4; load_ct();
    fault_kind = 3; fault_addr = 32'h10;
    run_walk("hang_corebase", 0, 0);
    fault_kind = 0;
    run_walk("repaired", 0, 0);

    // ack and err together on a CT read
    fill_random(); mem[10] = 32'd6; load_ct();
    fault_kind = 2; fault_addr = 32'h206;
    run_walk("ack_err_ct", 1, 0);

    // start while busy is ignored
    fill_random(); mem[10] = 32'd8; load_ct();
    fault_kind = 0;
    run_walk("start_busy", 0, 1);

    // Randomized walks
    for (int t = 0; t < 8; t++) begin
      fill_random();
      r = $urandom_range(0, 3);
      case (r)
        0: mem[10] = 32'd0;
        1: mem[10] = 32'($urandom_range(1, 10));
        2: mem[10] = 32'($urandom_range(60, 70));
        default: mem[10] = $urandom | 32'h8000_0000;
      endcase
      load_ct();
      if ($urandom_range(0, 2) == 0) begin
        fault_kind = $urandom_range(1, 3);
        fault_addr = acc_addr($urandom_range(0, 9 + ((mem[10] > 32'd64) ? 64 : int'(mem[10]))));
      end else begin
        fault_kind = 0;
      end
      run_walk($sformatf("rand%0d", t), $urandom_range(0, 2), 0);
    end

    // Reset in the middle of the CT phase, with start held during reset
    fill_random(); mem[10] = 32'd20; load_ct();
    fault_kind = 0; wait_states = 0; acc_num = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("midrst/en_before", bus_en, 1);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r = acc_num;
    check_all_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    check("midrst/no_access", 64'(acc_num), 64'(r));
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst/idle_busy", busy, 0);
    check("midrst/idle_en", bus_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
